// File: rtl/clint_timer.sv
// Machine timer / software interrupt slave: mtime, mtimecmp, msip and MTI/MSI generation.
// Optional prescaler on the mtime tick is built when CLINT_PRESCALE_EN is defined.
module clint_timer #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_word_sel,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              exc_en,
    output logic [3:0]        exc_code,
    output logic [63:0]       exc_val,
    output logic              irq_en,
    output logic [3:0]        irq_code,
    output logic [63:0]       irq_val
);

    localparam int unsigned XLEN = 64;

    localparam logic [ADDR_W-1:0] MSIP_ADDR     = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] MTIMECMP_ADDR = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] MTIME_ADDR    = ADDR_W'(16'hBFF8);

    localparam logic [3:0] CODE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CODE_STORE_FAULT = 4'd7;
    localparam logic [3:0] CODE_MSI         = 4'd3;
    localparam logic [3:0] CODE_MTI         = 4'd7;

    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic            msip_q, msip_d;
    logic            mtip_q, mtip_d;
    logic            msip_p_q, msip_p_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            exc_en_q, exc_en_d;
    logic [3:0]      exc_code_q, exc_code_d;
    logic [XLEN-1:0] exc_val_q, exc_val_d;
    logic            irq_en_q, irq_en_d;
    logic [3:0]      irq_code_q, irq_code_d;

    logic [XLEN-1:0] byte_mask_c;
    logic            hit_msip_c, hit_mtimecmp_c, hit_mtime_c;
    logic            fault_c, wr_c, rd_c;
    logic            tick_c;
    logic [XLEN-1:0] rd_word_c;

    // Address decode and access classification
    always_comb begin
        byte_mask_c = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask_c[i*8 +: 8] = {8{req_word_sel[i]}};
        end
        hit_msip_c     = (req_addr == MSIP_ADDR);
        hit_mtimecmp_c = (req_addr == MTIMECMP_ADDR);
        hit_mtime_c    = (req_addr == MTIME_ADDR);
        fault_c        = req_valid &&
                         ((req_addr[2:0] != 3'd0) ||
                          !(hit_msip_c || hit_mtimecmp_c || hit_mtime_c));
        wr_c           = req_valid && req_we && !fault_c && (req_word_sel != 8'd0);
        rd_c           = req_valid && !req_we && !fault_c;
    end

`ifdef CLINT_PRESCALE_EN
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;

    // Prescaler restarts whenever software rewrites mtime
    always_comb begin
        tick_c  = (presc_q == PRE_W'(TICK_DIV - 1));
        presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
        if (wr_c && hit_mtime_c) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_tick_div;

    assign tick_c          = 1'b1;
    assign unused_tick_div = ^32'(TICK_DIV);
`endif

    // Register file update; a store to mtime overrides the tick for the whole register
    always_comb begin
        mtime_d    = mtime_q + XLEN'(tick_c);
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_c && hit_mtime_c) begin
            mtime_d = (mtime_q & ~byte_mask_c) | (req_wdata & byte_mask_c);
        end
        if (wr_c && hit_mtimecmp_c) begin
            mtimecmp_d = (mtimecmp_q & ~byte_mask_c) | (req_wdata & byte_mask_c);
        end
        if (wr_c && hit_msip_c && req_word_sel[0]) begin
            msip_d = req_wdata[0];
        end
    end

    // Pending bits from post-update state, interrupt outputs one cycle behind them
    always_comb begin
        mtip_d     = (mtime_d >= mtimecmp_d);
        msip_p_d   = msip_d;
        irq_en_d   = mtip_q || msip_p_q;
        irq_code_d = 4'd0;
        if (msip_p_q) begin
            irq_code_d = CODE_MSI;
        end else if (mtip_q) begin
            irq_code_d = CODE_MTI;
        end
    end

    // Load data reflects pre-update register contents
    always_comb begin
        rd_word_c = '0;
        if (hit_msip_c) begin
            rd_word_c = {{(XLEN-1){1'b0}}, msip_q};
        end else if (hit_mtimecmp_c) begin
            rd_word_c = mtimecmp_q;
        end else if (hit_mtime_c) begin
            rd_word_c = mtime_q;
        end
    end

    always_comb begin
        rsp_valid_d = req_valid;
        rsp_rdata_d = rsp_rdata_q;
        if (req_valid) begin
            rsp_rdata_d = '0;
        end
        if (rd_c) begin
            rsp_rdata_d = rd_word_c & byte_mask_c;
        end
        exc_en_d   = fault_c;
        exc_code_d = 4'd0;
        exc_val_d  = '0;
        if (fault_c) begin
            exc_code_d = req_we ? CODE_STORE_FAULT : CODE_LOAD_FAULT;
            exc_val_d  = XLEN'(req_addr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            msip_p_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            exc_en_q    <= 1'b0;
            exc_code_q  <= 4'd0;
            exc_val_q   <= '0;
            irq_en_q    <= 1'b0;
            irq_code_q  <= 4'd0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            msip_p_q    <= msip_p_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            exc_en_q    <= exc_en_d;
            exc_code_q  <= exc_code_d;
            exc_val_q   <= exc_val_d;
            irq_en_q    <= irq_en_d;
            irq_code_q  <= irq_code_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign exc_en    = exc_en_q;
    assign exc_code  = exc_code_q;
    assign exc_val   = exc_val_q;
    assign irq_en    = irq_en_q;
    assign irq_code  = irq_code_q;
    assign irq_val   = '0;

endmodule

// File: tb/tb_clint_timer.sv
// Randomized self-checking bench for clint_timer against a cycle-level register model.
module tb_clint_timer;

`ifdef CLINT_PRESCALE_EN
    localparam int unsigned TICK_DIV = 4;
`else
    localparam int unsigned TICK_DIV = 1;
`endif
    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_word_sel = '0;
    logic [63:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              exc_en;
    logic [3:0]        exc_code;
    logic [63:0]       exc_val;
    logic              irq_en;
    logic [3:0]        irq_code;
    logic [63:0]       irq_val;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [63:0] m_time, m_cmp, m_rdata;
    logic        m_msip;
    int unsigned m_pre;
    bit          m_rdata_known;

    always #5 clk = ~clk;

    clint_timer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_word_sel(req_word_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
        .irq_en(irq_en), .irq_code(irq_code), .irq_val(irq_val)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input logic [7:0] ws);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{ws[i]}};
        return m;
    endfunction

    task automatic model_reset();
        m_time = '0;
        m_cmp = '1;
        m_msip = 1'b0;
        m_pre = 0;
        m_rdata = '0;
        m_rdata_known = 1'b1;
    endtask

    // Drive one request for one clock, advance the model, compare every output
    task automatic step(input bit v, input bit we, input logic [15:0] a,
                        input logic [7:0] ws, input logic [63:0] wd);
        logic [63:0] mask, rv, old_time;
        bit          hit, fault, tick, mti, exp_irq;
        logic [3:0]  exp_code;
        req_valid = v; req_we = we; req_addr = a; req_word_sel = ws; req_wdata = wd;
        mask = mask_of(ws);
        mti = (m_time >= m_cmp);
        exp_irq = mti || m_msip;
        exp_code = m_msip ? 4'd3 : (mti ? 4'd7 : 4'd0);
        hit = (a == 16'h0000) || (a == 16'h4000) || (a == 16'hBFF8);
        fault = v && ((a[2:0] != 3'd0) || !hit);
        rv = (a == 16'h0000) ? {63'd0, m_msip} : (a == 16'h4000) ? m_cmp :
             (a == 16'hBFF8) ? m_time : 64'd0;
        old_time = m_time;
        tick = (m_pre == TICK_DIV - 1);
        m_pre = tick ? 0 : m_pre + 1;
        if (tick) m_time = m_time + 64'd1;
        if (v && we && !fault && ws != 8'd0) begin
            if (a == 16'h0000 && ws[0]) m_msip = wd[0];
            if (a == 16'h4000) m_cmp = (m_cmp & ~mask) | (wd & mask);
            if (a == 16'hBFF8) begin
                m_time = (old_time & ~mask) | (wd & mask);
                m_pre = 0;
            end
        end
        if (v) begin
            if (fault) begin m_rdata = '0; m_rdata_known = 1'b1; end
            else if (!we) begin m_rdata = rv & mask; m_rdata_known = 1'b1; end
            else m_rdata_known = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(v));
        check("exc_en", 64'(exc_en), 64'(fault));
        if (fault) begin
            check("exc_code", 64'(exc_code), we ? 64'd7 : 64'd5);
            check("exc_val", exc_val, 64'(a));
        end
        if (m_rdata_known) check("rsp_rdata", rsp_rdata, m_rdata);
        check("irq_en", 64'(irq_en), 64'(exp_irq));
        check("irq_code", 64'(irq_code), 64'(exp_code));
        check("irq_val", irq_val, 64'd0);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 8'h00, 64'd0);
    endtask

    initial begin
        logic [63:0] prev_time, wd;
        logic [15:0] a;
        bit          seen;

        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_exc_en", 64'(exc_en), 64'd0);
        check("rst_exc_val", exc_val, 64'd0);
        check("rst_irq_en", 64'(irq_en), 64'd0);
        check("rst_irq_code", 64'(irq_code), 64'd0);
        rst = 1'b1;

        idle(3);
        check("reset_irq_idle", 64'(irq_en), 64'd0);
        step(1'b1, 1'b0, 16'h4000, 8'hFF, 64'd0);
        check("reset_cmp_val", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reset_cmp_valid", 64'(rsp_valid), 64'd1);

        // Timer interrupt rises one cycle after mtime reaches 20
        step(1'b1, 1'b1, 16'h4000, 8'hFF, 64'd20);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            prev_time = m_time;
            idle(1);
            if (irq_en) begin
                seen = 1'b1;
                check("mti_rise_time", prev_time, 64'd20);
                check("mti_rise_code", 64'(irq_code), 64'd7);
            end
        end
        if (!seen) check("mti_timeout", 64'd0, 64'd1);
        step(1'b1, 1'b1, 16'h4000, 8'hFF, 64'd100);
        check("mti_hold", 64'(irq_en), 64'd1);
        idle(1);
        check("mti_drop", 64'(irq_en), 64'd0);

        // MSI over MTI priority
        step(1'b1, 1'b1, 16'h4000, 8'hFF, 64'd0);
        idle(2);
        step(1'b1, 1'b1, 16'h0000, 8'h01, 64'd1);
        idle(1);
        check("prio_msi", 64'(irq_code), 64'd3);
        step(1'b1, 1'b1, 16'h0000, 8'h01, 64'd0);
        idle(1);
        check("prio_mti", 64'(irq_code), 64'd7);

        // Wrap of mtime past mtimecmp
        step(1'b1, 1'b1, 16'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(4 * TICK_DIV + 4);

        // Store to mtime in a tick cycle
        for (int i = 0; i < 8 && m_pre != TICK_DIV - 1; i++) idle(1);
        step(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'h0000_0000_1234_5678);
        step(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'd0);
        check("collide_mtime", rsp_rdata, 64'h0000_0000_1234_5678);

        // Access faults leave state untouched
        step(1'b1, 1'b0, 16'h0004, 8'hFF, 64'd0);
        check("fault_ld_code", 64'(exc_code), 64'd5);
        check("fault_ld_val", exc_val, 64'h4);
        step(1'b1, 1'b1, 16'h2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("fault_st_code", 64'(exc_code), 64'd7);
        check("fault_st_val", exc_val, 64'h2000);
        step(1'b1, 1'b0, 16'h4000, 8'hFF, 64'd0);
        check("fault_cmp_kept", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b0, 16'h0000, 8'hFF, 64'd0);
        check("fault_msip_kept", rsp_rdata, 64'd0);
        step(1'b1, 1'b1, 16'h4000, 8'h00, 64'd0);
        check("nop_no_fault", 64'(exc_en), 64'd0);

        // Byte-strobed store touches one byte only
        step(1'b1, 1'b1, 16'h4000, 8'h01, 64'h0000_0000_0000_00AB);
        step(1'b1, 1'b0, 16'h4000, 8'hFF, 64'd0);
        check("byte_store", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        step(1'b1, 1'b0, 16'h4000, 8'h0F, 64'd0);
        check("partial_load", rsp_rdata, 64'h0000_0000_FFFF_FFAB);

        // Prescaled advance sampled every 4 cycles
        step(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'd0);
            check("presc_mtime", rsp_rdata, 64'((4 * k) / TICK_DIV));
            idle(3);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0: a = 16'h0000;
                1, 2: a = 16'h4000;
                3: a = 16'hBFF8;
                4: a = 16'h4004;
                5: a = 16'h2000;
                default: a = 16'($urandom) & 16'hFFF8;
            endcase
            wd = ($urandom_range(0, 2) == 0) ? m_time + 64'($urandom_range(0, 12))
                                             : {$urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 8'($urandom), wd);
        end

        // Reset during an access suppresses its response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000; req_word_sel = 8'hFF;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
        check("rst_mid_irq", 64'(irq_en), 64'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        idle(2);
        step(1'b1, 1'b0, 16'h4000, 8'hFF, 64'd0);
        check("rst_mid_cmp", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
